data_mem_responder: RTL and testbench

// - Responder end of the processor's data-memory port: receives Address/WriteData/MemWrite, returns ReadData.
// - Decodes two regions: word RAM, and a small MMIO page (cycle counter, output stream FIFO, status, switch inputs).
// - ReadData is combinational from the address, so the single-cycle core needs no stall.
// - The MMIO FIFO drains to an external consumer (display/UART) over a valid/ready stream.

---
 rtl/mem_map_pkg.sv | 27 ++
 rtl/data_mem_responder_sync_fifo.sv | 47 ++++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map of the data-memory responder: MMIO page base, register offsets,
// STATUS bit positions and the absolute addresses software uses.
package mem_map_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_0400;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_TXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_SWITCH = 4'hC;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam logic [31:0] ADDR_CYCLE  = IO_BASE_DEFAULT + 32'(OFF_CYCLE);
    localparam logic [31:0] ADDR_TXDATA = IO_BASE_DEFAULT + 32'(OFF_TXDATA);
    localparam logic [31:0] ADDR_STATUS = IO_BASE_DEFAULT + 32'(OFF_STATUS);
    localparam logic [31:0] ADDR_SWITCH = IO_BASE_DEFAULT + 32'(OFF_SWITCH);

    // Word selector inside the 16-byte page.
    function automatic logic [1:0] io_word(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra MSB so full and
// empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the head slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus an MMIO page (cycle counter, output
// stream FIFO, status, synchronized switches); loads are combinational.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          MEM_DEPTH  = 64,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8,
    parameter int          SW_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWrite,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    output logic [31:0]         ReadData,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                bus_err
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] SEL_CYCLE  = io_word(OFF_CYCLE);
    localparam logic [1:0] SEL_TXDATA = io_word(OFF_TXDATA);
    localparam logic [1:0] SEL_STATUS = io_word(OFF_STATUS);
    localparam logic [1:0] SEL_SWITCH = io_word(OFF_SWITCH);

    logic [31:0]         word_addr;
    logic                in_ram;
    logic                in_io;
    logic [1:0]          io_sel;
    logic [AW-1:0]       ram_idx;
    logic [31:0]         ram [MEM_DEPTH];
    logic [31:0]         cycle;
    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_s2;
    logic                overflow;
    logic                push;
    logic                pop;
    logic                ovf_set;
    logic                ovf_clear;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [31:0]         status;

    assign word_addr = Address & 32'hFFFF_FFFC;
    assign in_ram    = (word_addr >> (AW + 2)) == 32'd0;
    assign in_io     = (word_addr[31:4] == IO_BASE[31:4]);
    assign io_sel    = word_addr[3:2];
    assign ram_idx   = word_addr[AW+1:2];

    // Output stream: out_data is valid whenever out_valid is high and holds
    // steady until the consumer takes it with out_valid && out_ready at an edge.
    assign out_valid = !fifo_empty;
    assign push      = MemWrite && in_io && (io_sel == SEL_TXDATA);
    assign pop       = out_valid && out_ready;
    assign ovf_set   = push && fifo_full && !pop;
    assign ovf_clear = MemWrite && in_io && (io_sel == SEL_STATUS) && WriteData[ST_OVERFLOW];

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (WriteData),
        .pop   (pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (MemWrite && in_ram) ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle    <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            overflow <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            cycle <= cycle + 32'd1;
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
            // A fresh overflow beats a simultaneous clear.
            if (ovf_set)        overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
            if (!in_ram && !in_io) bus_err <= 1'b1;
        end
    end

    always_comb begin
        status                        = '0;
        status[ST_COUNT_LSB +: CW]    = fifo_count;
        status[ST_OVERFLOW]           = overflow;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_FULL]               = fifo_full;
    end

    always_comb begin
        ReadData = '0;
        if (in_ram) begin
            ReadData = ram[ram_idx];
        end else if (in_io) begin
            case (io_sel)
                SEL_CYCLE:  ReadData = cycle;
                SEL_STATUS: ReadData = status;
                SEL_SWITCH: ReadData[SW_WIDTH-1:0] = sw_s2;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a behavioural
// model of the memory map, the output FIFO and the switch synchronizer.
module tb_data_mem_responder;

    localparam logic [31:0] IO_BASE   = 32'h0000_0400;
    localparam logic [31:0] RAM_BYTES = 32'd256;
    localparam int          FDEPTH    = 8;
    localparam logic [31:0] A_CYCLE   = IO_BASE + 32'h0;
    localparam logic [31:0] A_TX      = IO_BASE + 32'h4;
    localparam logic [31:0] A_STATUS  = IO_BASE + 32'h8;
    localparam logic [31:0] A_SWITCH  = IO_BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  sw_in = 8'h0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        bus_err;

    data_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .sw_in     (sw_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bus_err   (bus_err)
    );

    // Clock / timeout
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    // Reference model state
    logic [31:0] m_ram [64];
    bit          m_known [64];
    logic [31:0] exp_q [$];
    logic [7:0]  sw_log [$];
    logic [31:0] m_cycle;
    bit          m_ovf;
    bit          m_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] last_rd;
    logic [31:0] last_od;
    logic        last_ov;
    logic        last_be;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_io(input logic [31:0] a);
        return (a >= IO_BASE) && (a < IO_BASE + 32'd16);
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = exp_q.size();
        return (32'(n) << 8) | (m_ovf ? 32'd4 : 32'd0) | (n == 0 ? 32'd2 : 32'd0)
             | (n == FDEPTH ? 32'd1 : 32'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        if (a < RAM_BYTES) return m_ram[a[7:2]];
        if (is_io(a)) begin
            off = (a - IO_BASE) >> 2;
            if (off == 0) return m_cycle;
            if (off == 2) return model_status();
            if (off == 3) return (sw_log.size() >= 2) ? {24'h0, sw_log[sw_log.size()-2]} : 32'h0;
            return 32'h0;
        end
        return 32'h0;
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic rdy, input logic [7:0] sw);
        bit io;
        bit ram;
        bit pop;
        bit push;
        bit ovf_new;
        logic [31:0] off;
        io   = is_io(a);
        ram  = (a < RAM_BYTES);
        off  = (a - IO_BASE) >> 2;
        m_cycle = m_cycle + 32'd1;
        sw_log.push_back(sw);
        if (!ram && !io) m_err = 1'b1;
        if (we && ram) begin
            m_ram[a[7:2]]   = wd;
            m_known[a[7:2]] = 1'b1;
        end
        pop     = rdy && (exp_q.size() > 0);
        push    = we && io && (off == 1);
        ovf_new = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() == FDEPTH) ovf_new = 1'b1;
            else exp_q.push_back(wd);
        end
        if (ovf_new) m_ovf = 1'b1;
        else if (we && io && (off == 2) && wd[2]) m_ovf = 1'b0;
    endtask

    // Driver tasks
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic rdy, input logic [7:0] sw);
        @(negedge clk);
        MemWrite  = we;
        Address   = a;
        WriteData = wd;
        out_ready = rdy;
        sw_in     = sw;
        #1;
        last_rd = ReadData;
        last_od = out_data;
        last_ov = out_valid;
        last_be = bus_err;
        if (!(a < RAM_BYTES && !m_known[a[7:2]]))
            check("rdata", ReadData, model_read(a));
        check("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        check("bus_err", {31'h0, bus_err}, {31'h0, m_err});
        @(posedge clk);
        model_edge(we, a, wd, rdy, sw);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cycle = 32'h0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
        sw_log.delete();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, A_STATUS, 32'h0, rdy, sw_in);
    endtask

    logic [31:0] unmapped_list [4];

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        unmapped_list[0] = 32'h0000_0100;
        unmapped_list[1] = 32'h0000_0410;
        unmapped_list[2] = 32'h0000_8000;
        unmapped_list[3] = 32'h0000_03FC;

        do_reset();

        // Reset state and cycle counter
        for (int i = 0; i < 5; i++) step(1'b0, A_CYCLE, 32'h0, 1'b0, 8'h00);
        step(1'b0, A_CYCLE, 32'h0, 1'b0, 8'h00);
        check("cycle_after_5", last_rd, 32'd5);
        check("reset_out_valid", {31'h0, last_ov}, 32'h0);
        check("reset_out_data", last_od, 32'h0);
        check("reset_bus_err", {31'h0, last_be}, 32'h0);

        // Preload RAM
        for (int i = 0; i < 64; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 8'h00);

        // RAM store / load with ignored byte offset
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 8'h00);
        step(1'b0, 32'h10, 32'h0, 1'b0, 8'h00);
        check("load_0x10", last_rd, 32'hDEAD_BEEF);
        step(1'b0, 32'h13, 32'h0, 1'b0, 8'h00);
        check("load_0x13", last_rd, 32'hDEAD_BEEF);
        step(1'b0, 32'h14, 32'h0, 1'b0, 8'h00);

        // Overfill the FIFO then drain it
        for (int i = 1; i <= 9; i++) step(1'b1, A_TX, 32'(i), 1'b0, 8'h00);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 8'h00);
        check("status_overfull", last_rd, 32'h0000_0805);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, A_STATUS, 32'h0, 1'b1, 8'h00);
            check("drain_order", last_od, 32'(i));
        end
        step(1'b0, A_STATUS, 32'h0, 1'b1, 8'h00);
        check("drained_empty", {31'h0, last_ov}, 32'h0);

        // Clear overflow, then full push+pop in the same cycle
        step(1'b1, A_STATUS, 32'h4, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) step(1'b1, A_TX, 32'(100 + i), 1'b0, 8'h00);
        step(1'b1, A_TX, 32'hAA, 1'b1, 8'h00);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 8'h00);
        check("status_push_pop_full", last_rd, 32'h0000_0801);
        for (int i = 0; i < 8; i++) step(1'b0, A_STATUS, 32'h0, 1'b1, 8'h00);
        check("aa_last", last_od, 32'hAA);

        // Overflow then W1C
        for (int i = 1; i <= 9; i++) step(1'b1, A_TX, 32'(200 + i), 1'b0, 8'h00);
        step(1'b1, A_STATUS, 32'h0000_0004, 1'b0, 8'h00);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 8'h00);
        check("w1c_overflow", {31'h0, last_rd[2]}, 32'h0);
        idle(9, 1'b1);

        // Switch synchronizer latency
        step(1'b0, A_SWITCH, 32'h0, 1'b0, 8'h00);
        step(1'b0, A_SWITCH, 32'h0, 1'b0, 8'h00);
        step(1'b0, A_SWITCH, 32'h0, 1'b0, 8'h5A);
        check("sw_t", last_rd, 32'h0);
        step(1'b0, A_SWITCH, 32'h0, 1'b0, 8'h5A);
        check("sw_t1", last_rd, 32'h0);
        step(1'b0, A_SWITCH, 32'h0, 1'b0, 8'h5A);
        check("sw_t2", last_rd, 32'h5A);

        // Unmapped store
        step(1'b1, 32'h0000_8000, 32'h1234_5678, 1'b0, 8'h5A);
        step(1'b0, 32'h0, 32'h0, 1'b0, 8'h5A);
        check("bus_err_set", {31'h0, last_be}, 32'h1);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 8'h5A);
        check("unmapped_no_push", last_rd, 32'h0000_0002);

        // Reset in the middle of a drain
        for (int i = 1; i <= 6; i++) step(1'b1, A_TX, 32'(300 + i), 1'b0, 8'h5A);
        for (int i = 0; i < 3; i++) step(1'b0, A_STATUS, 32'h0, 1'b1, 8'h5A);
        do_reset();
        step(1'b0, A_STATUS, 32'h0, 1'b1, 8'h5A);
        check("rst_out_valid", {31'h0, last_ov}, 32'h0);
        check("rst_status_empty", {31'h0, last_rd[1]}, 32'h1);
        check("rst_bus_err", {31'h0, last_be}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            if (kind < 4)      a = 32'($urandom_range(0, 255));
            else if (kind < 9) a = IO_BASE + 32'($urandom_range(0, 15));
            else if (i > 200)  a = unmapped_list[$urandom_range(0, 3)];
            else               a = A_CYCLE;
            step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
